// File: rtl/fighter_fsm.sv
// fighter_fsm
// Per-player fighter controller. One instance per player; the state machine
// advances one game frame on each frame_tick pulse and owns the player's
// state, horizontal position, phase counter and sprite index. It supports
// walking, a three-phase attack (startup/active/recovery), blocking, and
// taking hits with hitstun and knockback. The position saturates at the
// arena bounds.
//
// Ports:
//   sys_clk       system clock, all logic on the rising edge
//   rst           synchronous reset, active-low
//   frame_tick    one-cycle pulse per game frame
//   inputs        player controls: bit0 left, bit1 right, bit2 attack, bit3 block
//   hit_in        one-cycle pulse: opponent attack connected
//   state         current state encoding
//   position      current horizontal position
//   sprite        sprite index {state, anim bit}, zero-extended
//   attack_active high while the attack hitbox is live
module fighter_fsm #(
  parameter int INPUT_DEPTH        = 4,
  parameter int STATE_DEPTH        = 3,
  parameter int POSITION_DEPTH     = 10,
  parameter int SPRITE_INDEX_DEPTH = 4,
  parameter int FRAME_CNT_DEPTH    = 5,
  parameter int START_POS          = 100,
  parameter int POS_MIN            = 0,
  parameter int POS_MAX            = 575,
  parameter int WALK_SPEED         = 2,
  parameter int STARTUP_FRAMES     = 3,
  parameter int ACTIVE_FRAMES      = 2,
  parameter int RECOVERY_FRAMES    = 6,
  parameter int HITSTUN_FRAMES     = 10,
  parameter int KNOCKBACK          = 8,
  parameter int KNOCKBACK_DIR      = 0,
  parameter int ANIM_PERIOD        = 8
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          frame_tick,
  input  logic [INPUT_DEPTH-1:0]        inputs,
  input  logic                          hit_in,
  output logic [STATE_DEPTH-1:0]        state,
  output logic [POSITION_DEPTH-1:0]     position,
  output logic [SPRITE_INDEX_DEPTH-1:0] sprite,
  output logic                          attack_active
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WALK_L       = 3'd1,
    WALK_R       = 3'd2,
    ATK_STARTUP  = 3'd3,
    ATK_ACTIVE   = 3'd4,
    ATK_RECOVERY = 3'd5,
    HITSTUN      = 3'd6,
    BLOCK        = 3'd7
  } state_t;

  // Position math is one bit wider so that sums and differences never wrap
  // before the clamp is applied.
  localparam int PW = POSITION_DEPTH + 1;
  typedef logic [PW-1:0] pos_ext_t;
  typedef logic [POSITION_DEPTH-1:0] pos_t;
  typedef logic [FRAME_CNT_DEPTH-1:0] cnt_t;

  localparam pos_ext_t POS_MIN_X   = pos_ext_t'(POS_MIN);
  localparam pos_ext_t POS_MAX_X   = pos_ext_t'(POS_MAX);
  localparam pos_ext_t WALK_X      = pos_ext_t'(WALK_SPEED);
  localparam pos_ext_t KNOCK_X     = pos_ext_t'(KNOCKBACK);
  localparam pos_t     START_P     = pos_t'(START_POS);

  localparam cnt_t STARTUP_LAST  = cnt_t'(STARTUP_FRAMES - 1);
  localparam cnt_t ACTIVE_LAST   = cnt_t'(ACTIVE_FRAMES - 1);
  localparam cnt_t RECOVERY_LAST = cnt_t'(RECOVERY_FRAMES - 1);
  localparam cnt_t HITSTUN_LAST  = cnt_t'(HITSTUN_FRAMES - 1);

  localparam int ANIM_W = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_PERIOD - 1);

  state_t            state_q, state_nxt;
  pos_t              pos_q, pos_nxt;
  cnt_t              cnt_q, cnt_nxt;
  logic [ANIM_W-1:0] anim_cnt_q, anim_cnt_nxt;
  logic              anim_bit_q, anim_bit_nxt;
  logic              hit_pending_q;
  logic              hit_now;

  function automatic pos_t sat_dec(input pos_t p, input pos_ext_t amt);
    pos_ext_t ext;
    ext = {1'b0, p};
    if (ext < amt + POS_MIN_X) return pos_t'(POS_MIN_X);
    return pos_t'(ext - amt);
  endfunction

  function automatic pos_t sat_inc(input pos_t p, input pos_ext_t amt);
    pos_ext_t sum;
    sum = {1'b0, p} + amt;
    if (sum > POS_MAX_X) return pos_t'(POS_MAX_X);
    return pos_t'(sum);
  endfunction

  function automatic logic is_anim(input state_t s);
    return (s == IDLE) || (s == WALK_L) || (s == WALK_R);
  endfunction

  // Next-frame logic: what the registers become if this edge carries a
  // frame_tick. A pending hit beats the timed phases, which beat the
  // controls. A hit arriving on the tick edge itself counts as pending.
  always_comb begin
    state_nxt    = state_q;
    pos_nxt      = pos_q;
    cnt_nxt      = cnt_q;
    anim_cnt_nxt = anim_cnt_q;
    anim_bit_nxt = anim_bit_q;
    hit_now      = hit_pending_q | hit_in;

    if (hit_now) begin
      // A blocked hit is simply swallowed; the player keeps blocking.
      if (state_q != BLOCK) begin
        state_nxt = HITSTUN;
        cnt_nxt   = HITSTUN_LAST;
        pos_nxt   = (KNOCKBACK_DIR != 0) ? sat_inc(pos_q, KNOCK_X)
                                         : sat_dec(pos_q, KNOCK_X);
      end
    end else begin
      case (state_q)
        ATK_STARTUP: begin
          if (cnt_q != '0) cnt_nxt = cnt_q - 1'b1;
          else begin
            state_nxt = ATK_ACTIVE;
            cnt_nxt   = ACTIVE_LAST;
          end
        end
        ATK_ACTIVE: begin
          if (cnt_q != '0) cnt_nxt = cnt_q - 1'b1;
          else begin
            state_nxt = ATK_RECOVERY;
            cnt_nxt   = RECOVERY_LAST;
          end
        end
        ATK_RECOVERY, HITSTUN: begin
          if (cnt_q != '0) cnt_nxt = cnt_q - 1'b1;
          else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          cnt_nxt = '0;
          if (inputs[2]) begin
            state_nxt = ATK_STARTUP;
            cnt_nxt   = STARTUP_LAST;
          end else if (inputs[3]) begin
            state_nxt = BLOCK;
          end else if (inputs[0] && !inputs[1]) begin
            state_nxt = WALK_L;
            pos_nxt   = sat_dec(pos_q, WALK_X);
          end else if (inputs[1] && !inputs[0]) begin
            state_nxt = WALK_R;
            pos_nxt   = sat_inc(pos_q, WALK_X);
          end else begin
            state_nxt = IDLE;
          end
        end
      endcase
    end

    // The idle/walk animation only runs while the player stays in the same
    // animated state; any change restarts it from frame zero.
    if (is_anim(state_nxt) && (state_nxt == state_q)) begin
      if (anim_cnt_q == ANIM_LAST) begin
        anim_cnt_nxt = '0;
        anim_bit_nxt = ~anim_bit_q;
      end else begin
        anim_cnt_nxt = anim_cnt_q + 1'b1;
      end
    end else begin
      anim_cnt_nxt = '0;
      anim_bit_nxt = 1'b0;
    end
  end

  // Frame registers advance only on frame_tick. Between ticks a hit pulse is
  // latched so that it is consumed on the next tick.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      pos_q         <= START_P;
      cnt_q         <= '0;
      anim_cnt_q    <= '0;
      anim_bit_q    <= 1'b0;
      hit_pending_q <= 1'b0;
    end else if (frame_tick) begin
      state_q       <= state_nxt;
      pos_q         <= pos_nxt;
      cnt_q         <= cnt_nxt;
      anim_cnt_q    <= anim_cnt_nxt;
      anim_bit_q    <= anim_bit_nxt;
      hit_pending_q <= 1'b0;
    end else if (hit_in) begin
      hit_pending_q <= 1'b1;
    end
  end

  // Outputs derive only from registered state, so they change the cycle
  // after a tick and hold otherwise.
  assign state         = STATE_DEPTH'(state_q);
  assign position      = pos_q;
  assign sprite        = SPRITE_INDEX_DEPTH'({state_q, anim_bit_q & is_anim(state_q)});
  assign attack_active = (state_q == ATK_ACTIVE);

endmodule

// File: tb/tb_fighter_fsm.sv
// tb_fighter_fsm
// Directed bench for fighter_fsm: idle animation, walking into both arena
// bounds, the attack phase timing, hit with knockback and hitstun restart,
// blocking a hit, and reset in the middle of hitstun.
module tb_fighter_fsm;

  logic       sys_clk;
  logic       rst;
  logic       frame_tick;
  logic [3:0] inputs;
  logic       hit_in;
  logic [2:0] state;
  logic [9:0] position;
  logic [3:0] sprite;
  logic       attack_active;

  int checks = 0;
  int errors = 0;

  fighter_fsm dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .inputs        (inputs),
    .hit_in        (hit_in),
    .state         (state),
    .position      (position),
    .sprite        (sprite),
    .attack_active (attack_active)
  );

  // 10 ns clock; stimulus changes and sampling both happen on the falling edge.
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Drive one frame: tick high for one cycle with the given controls and an
  // optional coincident hit. Controls stay held afterwards.
  task automatic applyStimulus(input logic [3:0] ctl, input logic hit);
    @(negedge sys_clk);
    inputs     = ctl;
    frame_tick = 1'b1;
    hit_in     = hit;
    @(negedge sys_clk);
    frame_tick = 1'b0;
    hit_in     = 1'b0;
  endtask

  // Single-cycle hit pulse between frame ticks.
  task automatic pulseHit();
    @(negedge sys_clk);
    hit_in = 1'b1;
    @(negedge sys_clk);
    hit_in = 1'b0;
  endtask

  // Compare all four outputs against the expected values.
  task automatic checkOutput(input string tag, input logic [2:0] st,
                             input logic [9:0] pos, input logic [3:0] spr,
                             input logic atk);
    checks++;
    assert (state === st) else begin
      errors++;
      $error("[TB] FAIL %s state: observed %0d expected %0d", tag, state, st);
    end
    checks++;
    assert (position === pos) else begin
      errors++;
      $error("[TB] FAIL %s position: observed %0d expected %0d", tag, position, pos);
    end
    checks++;
    assert (sprite === spr) else begin
      errors++;
      $error("[TB] FAIL %s sprite: observed %0d expected %0d", tag, sprite, spr);
    end
    checks++;
    assert (attack_active === atk) else begin
      errors++;
      $error("[TB] FAIL %s attack_active: observed %0d expected %0d", tag, attack_active, atk);
    end
  endtask

  initial begin
    logic [9:0] exp_walk[5];
    logic [2:0] exp_atk[11];
    exp_walk = '{10'd572, 10'd574, 10'd575, 10'd575, 10'd575};
    exp_atk  = '{3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0};

    rst        = 1'b0;
    frame_tick = 1'b0;
    inputs     = 4'b0000;
    hit_in     = 1'b0;
    repeat (3) @(negedge sys_clk);
    checkOutput("reset", 3'd0, 10'd100, 4'd0, 1'b0);
    rst = 1'b1;

    $display("[TB] idle animation");
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(4'b0000, 1'b0);
      checkOutput($sformatf("idle_t%0d", k), 3'd0, 10'd100,
                  ((k >= 8) && (k < 16)) ? 4'd1 : 4'd0, 1'b0);
    end

    $display("[TB] walk right into upper bound");
    repeat (235) applyStimulus(4'b0010, 1'b0);
    checkOutput("walk_r_570", 3'd2, 10'd570, 4'd5, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0010, 1'b0);
      checkOutput($sformatf("walk_r_clamp%0d", k), 3'd2, exp_walk[k], 4'd5, 1'b0);
    end

    $display("[TB] walk left into lower bound");
    repeat (300) applyStimulus(4'b0001, 1'b0);
    checkOutput("walk_l_clamp", 3'd1, 10'd0, 4'd3, 1'b0);

    $display("[TB] attack phases with left held");
    applyStimulus(4'b0100, 1'b0);
    checkOutput("atk_start", 3'd3, 10'd0, 4'd6, 1'b0);
    for (int k = 0; k < 11; k++) begin
      applyStimulus(4'b0001, 1'b0);
      checkOutput($sformatf("atk_phase%0d", k), exp_atk[k], 10'd0,
                  {exp_atk[k], 1'b0}, exp_atk[k] == 3'd4);
    end
    applyStimulus(4'b0001, 1'b0);
    checkOutput("after_atk_walk", 3'd1, 10'd0, 4'd2, 1'b0);

    $display("[TB] hit during active phase");
    repeat (150) applyStimulus(4'b0010, 1'b0);
    checkOutput("walk_r_300", 3'd2, 10'd300, 4'd4, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("idle_300", 3'd0, 10'd300, 4'd0, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("active1", 3'd4, 10'd300, 4'd8, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("active2", 3'd4, 10'd300, 4'd8, 1'b1);
    pulseHit();
    checkOutput("hold_no_tick", 3'd4, 10'd300, 4'd8, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("hitstun_entry", 3'd6, 10'd292, 4'd12, 1'b0);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(4'b0001, 1'b0);
      checkOutput($sformatf("hitstun%0d", k), 3'd6, 10'd292, 4'd12, 1'b0);
    end
    applyStimulus(4'b0000, 1'b0);
    checkOutput("hitstun_exit", 3'd0, 10'd292, 4'd0, 1'b0);

    $display("[TB] blocked hit");
    applyStimulus(4'b1000, 1'b0);
    checkOutput("block", 3'd7, 10'd292, 4'd14, 1'b0);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("block_hit", 3'd7, 10'd292, 4'd14, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("block_release", 3'd0, 10'd292, 4'd0, 1'b0);

    $display("[TB] hit restart in hitstun");
    pulseHit();
    applyStimulus(4'b0000, 1'b0);
    checkOutput("hit2", 3'd6, 10'd284, 4'd12, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    pulseHit();
    applyStimulus(4'b0000, 1'b0);
    checkOutput("hit_restart", 3'd6, 10'd276, 4'd12, 1'b0);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(4'b0000, 1'b0);
      checkOutput($sformatf("restart_hs%0d", k), 3'd6, 10'd276, 4'd12, 1'b0);
    end
    applyStimulus(4'b0000, 1'b0);
    checkOutput("restart_exit", 3'd0, 10'd276, 4'd0, 1'b0);

    $display("[TB] reset mid-hitstun");
    pulseHit();
    applyStimulus(4'b0000, 1'b0);
    checkOutput("hit3", 3'd6, 10'd268, 4'd12, 1'b0);
    @(negedge sys_clk);
    rst        = 1'b0;
    frame_tick = 1'b1;
    hit_in     = 1'b1;
    @(negedge sys_clk);
    rst        = 1'b1;
    frame_tick = 1'b0;
    hit_in     = 1'b0;
    checkOutput("mid_reset", 3'd0, 10'd100, 4'd0, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("no_stale_hit", 3'd0, 10'd100, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fighter_fsm.md
Name: fighter_fsm

Overview:
Parametrised per-player fighter controller; game_logic instantiates one per player instead of holding hand-coded player registers. Advances one game frame per frame_tick and owns the player's state, position, frame counter and sprite index. Adds timed attack phases (startup/active/recovery), blocking, hit handling with hitstun and knockback, and saturating arena bounds.

Parameters:
INPUT_DEPTH, 4, width of player input bus (bit0 left, bit1 right, bit2 attack, bit3 block; higher bits ignored)
STATE_DEPTH, 3, width of state output
POSITION_DEPTH, 10, width of horizontal position
SPRITE_INDEX_DEPTH, 4, width of sprite index (must be >= STATE_DEPTH+1)
FRAME_CNT_DEPTH, 5, width of internal phase counter
START_POS, 100, position after reset
POS_MIN, 0, leftmost legal position
POS_MAX, 575, rightmost legal position
WALK_SPEED, 2, pixels moved per frame while walking
STARTUP_FRAMES, 3, attack startup length in frames (>=1)
ACTIVE_FRAMES, 2, attack active length in frames (>=1)
RECOVERY_FRAMES, 6, attack recovery length in frames (>=1)
HITSTUN_FRAMES, 10, hitstun length in frames (>=1)
KNOCKBACK, 8, pixels pushed per hit
KNOCKBACK_DIR, 0, 0 = knockback decreases position, 1 = increases
ANIM_PERIOD, 8, frames per idle/walk animation toggle (>=1)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-low
frame_tick  in  1  one-cycle pulse per game frame, synchronous to sys_clk
inputs  in  INPUT_DEPTH  debounced player controls
hit_in  in  1  one-cycle pulse from collision logic: opponent attack connected
state  out  STATE_DEPTH  current state encoding
position  out  POSITION_DEPTH  current horizontal position
sprite  out  SPRITE_INDEX_DEPTH  sprite index for renderer
attack_active  out  1  high while in ATK_ACTIVE (hitbox live)

Behaviour:
- Reset (rst=0 at edge): state=IDLE, position=START_POS, sprite=0, attack_active=0, phase counter=0, anim counter/bit=0, hit_pending=0. Reset overrides frame_tick and hit_in that cycle.
- States: IDLE=0, WALK_L=1, WALK_R=2, ATK_STARTUP=3, ATK_ACTIVE=4, ATK_RECOVERY=5, HITSTUN=6, BLOCK=7.
- hit_in any cycle sets hit_pending; cleared on the next frame_tick edge (consumed). hit_in coincident with frame_tick is consumed that tick.
- All state/position/sprite updates occur only on edges where frame_tick=1; outputs registered, valid the cycle after the tick.
- Tick priority: (1) hit pending (incl. same-cycle hit_in); (2) timed phase handling; (3) input decode.
- Hit: in BLOCK, hit discarded, state unchanged. Otherwise -> HITSTUN, counter=HITSTUN_FRAMES-1, position moved KNOCKBACK per KNOCKBACK_DIR. Interrupts attack phases; hit in HITSTUN restarts counter and re-applies knockback.
- Timed states (ATK_*, HITSTUN): on entry counter=N-1; each tick, counter!=0 -> decrement; counter==0 -> exit. Each phase lasts exactly N ticks. STARTUP->ACTIVE->RECOVERY->IDLE; HITSTUN->IDLE. Inputs ignored in timed states.
- Input decode (IDLE/WALK_*/BLOCK): attack -> ATK_STARTUP (counter=STARTUP_FRAMES-1); else block -> BLOCK; else left only -> WALK_L; right only -> WALK_R; none or both -> IDLE. Movement applied on the same tick as entering/staying in WALK_*.
- Position arithmetic in POSITION_DEPTH+1 bits, saturating: decrease clamps at POS_MIN, increase clamps at POS_MAX; never wraps.
- Animation: anim counter counts ticks in IDLE/WALK_*; at ANIM_PERIOD-1 it wraps to 0 and anim bit toggles. Leaving IDLE/WALK_* or changing between them clears counter and bit.
- sprite = {state, anim bit} zero-extended; anim bit forced 0 outside IDLE/WALK_*. attack_active = (next state == ATK_ACTIVE), registered with state.
- No frame_tick: all outputs hold; only hit_pending may change.

Test Plan:
- Reset release, no inputs, 20 ticks -> state=0, position=100, sprite toggles 0->1 after 8 ticks, back to 0 after 16.
- Hold right (inputs=4'b0010) from position 570, 5 ticks -> WALK_R, position 572, 574, 575, 575, 575 (clamped, no wrap).
- Attack pulse at one tick -> STARTUP for 3 ticks, ACTIVE 2 ticks (attack_active=1 exactly 2 ticks), RECOVERY 6 ticks, then IDLE; left input during phases ignored.
- hit_in during 2nd ACTIVE tick (between ticks), position 300 -> next tick HITSTUN, position 292, attack_active=0; IDLE after 10 ticks.
- Hold block, hit_in coincident with frame_tick -> state stays BLOCK, position unchanged, hit_pending clear after tick.
- rst=0 mid-HITSTUN with frame_tick=1 and hit_in=1 -> next cycle state=0, position=100, sprite=0; subsequent tick shows no stale hit.
